phase_ring_sync: RTL and testbench
==================================

# phase_ring_sync

Clocked, parametrised phase-token sequencer for the CPU control path. Drives `NUM_PH` dual-rail phase outputs in a ring, one phase active at a time. Each step runs a four-phase (return-to-zero) handshake against a configurable join of acknowledgers per phase. Adds run/stop control, a rotation counter and a handshake watchdog, and targets synchronous integration of the phase generator.

## Interface
- `NUM_PH`, 3, number of phases in the ring (2..8)
- `NUM_ACK`, 3, acknowledge inputs per phase (1..8)
- `ACK_MASK`, 9'b001_001_111, `NUM_PH*NUM_ACK` bits; bit `i*NUM_ACK+j` set = ack `j` joins phase `i`
- `SYNC_STAGES`, 2, synchroniser flops on each ack input (>=2)
- `TIMEOUT`, 1024, watchdog limit in cycles per wait; 0 disables
- `CNT_W`, 16, width of rotation counter
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `run`  in  1  1 = keep rotating; 0 = stop at next spacer
- `clr_err`  in  1  leaves ERR state
- `ack`  in  `NUM_PH*NUM_ACK`  asynchronous acknowledges, slice `i` belongs to phase `i`
- `ph`  out  `2*NUM_PH`  dual-rail phases, `ph[2i+1:2i]` = phase `i`
- `active_idx`  out  `$clog2(NUM_PH)`  index of token-holding phase
- `rot_cnt`  out  `CNT_W`  completed ring rotations, wraps modulo 2^CNT_W
- `err`  out  1  watchdog fired

## Operation
- Encoding per phase: 00 spacer, 10 active (token), 01 valid-inactive; 11 never driven.
- Join: `all_hi(k)` = every masked synced ack of phase k is 1; `all_lo(k)` = every masked one is 0. An empty mask makes both true.
- All outputs are registered. Unmasked ack bits are ignored.
- States:
  - IDLE: all `ph` = 00. Go to DATA when `run`=1 and `all_lo(active_idx)`.
  - DATA: `ph[active_idx]`=10, all others 01. On `all_hi(active_idx)` go to SPACER.
  - SPACER: all `ph`=00. On `all_lo(active_idx)`:
    - advance `active_idx` = (idx+1) mod NUM_PH;
    - on wrap NUM_PH-1 -> 0, increment `rot_cnt`;
    - go to DATA if `run`=1, else IDLE.
  - ERR: all `ph`=00, `err`=1. On `clr_err`=1 go to IDLE and clear `err`. `active_idx` and `rot_cnt` are held.
- Watchdog: counter clears on every state change. It counts cycles spent in DATA/SPACER. On reaching `TIMEOUT` it goes to ERR. `clr_err` has no effect outside ERR.
- `run` falling mid-step: the current step completes through SPACER, then the block stops in IDLE. `run` is sampled only in IDLE and at SPACER exit.
- Reset (async, any state): state IDLE, `ph`=0, `active_idx`=0, `rot_cnt`=0, `err`=0, sync flops and watchdog cleared.

## Timing
- Ack to FSM latency: an ack change stable before edge t is visible to the join at edge t+SYNC_STAGES-1. `ph` updates at edge t+SYNC_STAGES.
- Each state transition takes exactly one clock edge. No state is skipped in a single cycle.
- Minimum step (immediate acks, SYNC_STAGES=2): DATA held 3 cycles and SPACER held 3 cycles.
- Between any two DATA words the outputs show at least one cycle of all-00. A phase never goes from 10 directly to 01 or back.
- Watchdog fires on the edge where its count equals TIMEOUT. ERR outputs are valid the cycle after that edge.

## Test plan
- Reset with defaults, `run`=1, acks echo `ph` active bit with 0 delay -> `ph` sequence 00 / 01_01_10 / 00 / 01_10_01 / 00 / 10_01_01. `rot_cnt`=1 after phase 2 spacer. `active_idx` sequence 0,1,2,0.
- Phase 0 join: raise ack[0], ack[1] but hold ack[2]=0 -> stays in DATA. Raise ack[2] -> spacer 2 cycles later. Unmasked ack[4]=1 throughout has no effect.
- `run`=0 asserted while in DATA of phase 1 -> spacer, `active_idx`=2, IDLE with `ph`=0. Reassert `run` -> phase 2 token 01 set as 10_01_01 (phase 2 active).
- TIMEOUT=8, never acknowledge -> `err`=1 and `ph`=0 after 8 cycles in DATA. Pulse `clr_err` -> IDLE, then DATA resumes at the same `active_idx`.
- Assert `rst_n`=0 mid-SPACER -> outputs 0 immediately without a clock edge. Release -> IDLE, `active_idx`=0.
- CNT_W=2, run 5 rotations -> `rot_cnt` reads 1,2,3,0,1.

Source files
------------

// File: rtl/phase_ring_sync.sv
// rtl/phase_ring_sync.sv - dual-rail phase-token ring sequencer with synchronised ack join and watchdog
module phase_ring_sync #(
  parameter int                        NUM_PH      = 3,
  parameter int                        NUM_ACK     = 3,
  parameter logic [NUM_PH*NUM_ACK-1:0] ACK_MASK    = 9'b001_001_111,
  parameter int                        SYNC_STAGES = 2,
  parameter int                        TIMEOUT     = 1024,
  parameter int                        CNT_W       = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        run,
  input  logic                        clr_err,
  input  logic [NUM_PH*NUM_ACK-1:0]   ack,
  output logic [2*NUM_PH-1:0]         ph,
  output logic [$clog2(NUM_PH)-1:0]   active_idx,
  output logic [CNT_W-1:0]            rot_cnt,
  output logic                        err
);

  localparam int AW = $clog2(NUM_PH);
  localparam int NA = NUM_PH * NUM_ACK;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_SPACER, S_ERR} state_t;

  state_t              state_q, state_d;
  logic [NA-1:0]       sync_q [SYNC_STAGES];
  logic [NA-1:0]       sync_d [SYNC_STAGES];
  logic [AW-1:0]       idx_q, idx_d;
  logic [CNT_W-1:0]    rot_q, rot_d;
  logic [WW-1:0]       wd_q, wd_d;
  logic [2*NUM_PH-1:0] ph_q, ph_d;
  logic                err_q, err_d;
  logic [NA-1:0]       hi_ok, lo_ok;
  logic                all_hi, all_lo, wd_expire, wrap;

  always_comb begin
    sync_d[0] = ack;
    for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
  end

  // Unmasked bits are forced to "satisfied" so an empty join is trivially both high and low.
  always_comb begin
    hi_ok  = sync_q[SYNC_STAGES-1] | ~ACK_MASK;
    lo_ok  = ~sync_q[SYNC_STAGES-1] | ~ACK_MASK;
    all_hi = 1'b1;
    all_lo = 1'b1;
    for (int i = 0; i < NUM_PH; i++) begin
      if (AW'(i) == idx_q) begin
        all_hi = &hi_ok[i*NUM_ACK +: NUM_ACK];
        all_lo = &lo_ok[i*NUM_ACK +: NUM_ACK];
      end
    end
  end

  assign wd_expire = (TIMEOUT != 0) && (wd_q == WW'(TIMEOUT - 1));
  assign wrap      = (idx_q == AW'(NUM_PH - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rot_d   = rot_q;
    wd_d    = wd_q;
    case (state_q)
      S_IDLE:   if (run && all_lo) state_d = S_DATA;
      S_DATA: begin
        if (all_hi)         state_d = S_SPACER;
        else if (wd_expire) state_d = S_ERR;
      end
      S_SPACER: begin
        if (all_lo) begin
          idx_d   = wrap ? '0 : idx_q + AW'(1);
          rot_d   = wrap ? rot_q + CNT_W'(1) : rot_q;
          state_d = run ? S_DATA : S_IDLE;
        end else if (wd_expire) begin
          state_d = S_ERR;
        end
      end
      S_ERR:    if (clr_err) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (state_d != state_q)
      wd_d = '0;
    else if ((TIMEOUT != 0) && (state_q == S_DATA || state_q == S_SPACER))
      wd_d = wd_q + WW'(1);

    // Outputs are decoded from the next state so they land in the same edge as the transition.
    err_d = (state_d == S_ERR);
    ph_d  = '0;
    if (state_d == S_DATA) begin
      for (int i = 0; i < NUM_PH; i++)
        ph_d[2*i +: 2] = (AW'(i) == idx_d) ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      state_q <= S_IDLE;
      idx_q   <= '0;
      rot_q   <= '0;
      wd_q    <= '0;
      ph_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= sync_d[s];
      state_q <= state_d;
      idx_q   <= idx_d;
      rot_q   <= rot_d;
      wd_q    <= wd_d;
      ph_q    <= ph_d;
      err_q   <= err_d;
    end
  end

  assign ph         = ph_q;
  assign active_idx = idx_q;
  assign rot_cnt    = rot_q;
  assign err        = err_q;

endmodule

// File: tb/tb_phase_ring_sync.sv
// tb/tb_phase_ring_sync.sv - scoreboard bench for phase_ring_sync
module tb_phase_ring_sync;
  localparam logic [8:0] MASK = 9'b001_001_111;

  logic       clk = 1'b0;
  logic       rst_n, run, clr_err;
  logic [8:0] ack;
  logic [5:0] ph;
  logic [1:0] active_idx;
  logic [1:0] rot_cnt;
  logic       err;

  phase_ring_sync #(
    .NUM_PH(3), .NUM_ACK(3), .ACK_MASK(MASK), .SYNC_STAGES(2), .TIMEOUT(8), .CNT_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .clr_err(clr_err), .ack(ack),
    .ph(ph), .active_idx(active_idx), .rot_cnt(rot_cnt), .err(err)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [5:0] ph;
    logic [1:0] idx;
    logic [1:0] rot;
    logic       err;
    int         gap;
  } exp_t;

  exp_t       q[$];
  int         total = 0, bad = 0, cyc = 0, m_steps = 0;
  logic       echo_en = 1'b0;
  logic [8:0] man = '0;
  logic [8:0] drv_b;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  function automatic logic [5:0] dword(input int idx);
    logic [5:0] w;
    for (int i = 0; i < 3; i++) w[2*i +: 2] = (i == idx) ? 2'b10 : 2'b01;
    return w;
  endfunction

  // Reference: after n completed steps the token sits on phase n mod 3, rotations = n div 3.
  task automatic push(input logic [5:0] p, input logic e, input int gap);
    exp_t x;
    x.ph  = p;
    x.idx = 2'(m_steps % 3);
    x.rot = 2'((m_steps / 3) % 4);
    x.err = e;
    x.gap = gap;
    q.push_back(x);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    drv_b = man;
    if (echo_en)
      for (int i = 0; i < 3; i++) drv_b[3*i +: 3] = {3{ph[2*i+1]}};
    ack = (drv_b & MASK) | (9'($urandom) & ~MASK);
  end

  initial begin
    logic [11:0] prev, cur;
    int          last;
    exp_t        x;
    prev = '0;
    last = 0;
    forever begin
      @(negedge clk);
      cyc++;
      cur = {ph, active_idx, rot_cnt, err};
      if (cur !== prev) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_change: got ph=%b idx=%0d rot=%0d err=%0d, required no change",
                   ph, active_idx, rot_cnt, err);
        end else begin
          x = q.pop_front();
          chk("ph", int'(ph), int'(x.ph));
          chk("active_idx", int'(active_idx), int'(x.idx));
          chk("rot_cnt", int'(rot_cnt), int'(x.rot));
          chk("err", int'(err), int'(x.err));
          if (x.gap != 0) chk("hold_cycles", cyc - last, x.gap);
        end
        prev = cur;
        last = cyc;
      end
    end
  end

  task automatic tick(input int n);
    if (n > 0) begin
      repeat (n) @(negedge clk);
      #2;
    end
  endtask

  task automatic drain(input string nm);
    int b;
    b = 0;
    while (q.size() != 0 && b < 400) begin
      tick(1);
      b++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d expected words outstanding, required 0", nm, q.size());
      q.delete();
    end
  endtask

  task automatic data_half(input int k, input bit partial);
    push(6'b0, 1'b0, k + 4);
    clr_err = 1'($urandom);
    if (partial) man = 9'b000_000_011;
    tick(k);
    man = MASK & (9'b111 << (3 * (m_steps % 3)));
    drain("spacer_entry");
  endtask

  task automatic spacer_half(input int k, input bit stop);
    int m;
    clr_err = 1'b0;
    m_steps++;
    if (stop) begin
      run = 1'b0;
      push(6'b0, 1'b0, k + 4);
    end else begin
      push(dword(m_steps % 3), 1'b0, k + 4);
    end
    tick(k);
    man = '0;
    drain("step_exit");
    if (stop) begin
      m = $urandom_range(3, 0);
      tick(m);
      push(dword(m_steps % 3), 1'b0, m + 1);
      run = 1'b1;
      drain("restart");
    end
  endtask

  task automatic step();
    data_half($urandom_range(3, 0), 1'b0);
    spacer_half($urandom_range(3, 0), ($urandom % 4) == 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b0; run = 1'b0; clr_err = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    chk("reset_ph", int'(ph), 0);
    chk("reset_idx", int'(active_idx), 0);
    chk("reset_rot", int'(rot_cnt), 0);
    chk("reset_err", int'(err), 0);

    // Zero-delay echo: minimum step, five-plus rotations through the 2-bit counter.
    push(dword(0), 1'b0, 0);
    run = 1'b1;
    echo_en = 1'b1;
    for (int s = 0; s < 16; s++) begin
      push(6'b0, 1'b0, 3);
      m_steps++;
      push(dword(m_steps % 3), 1'b0, 3);
    end
    drain("echo_rotations");

    // Drop run while phase 1 holds the token.
    run = 1'b0;
    push(6'b0, 1'b0, 3);
    m_steps++;
    push(6'b0, 1'b0, 3);
    drain("stop_to_idle");
    tick(2);
    echo_en = 1'b0;
    push(dword(m_steps % 3), 1'b0, 3);
    run = 1'b1;
    drain("resume_phase2");

    data_half($urandom_range(3, 0), 1'b0);
    spacer_half($urandom_range(3, 0), 1'b0);
    chk("join_phase", m_steps % 3, 0);
    data_half(3, 1'b1);
    spacer_half($urandom_range(3, 0), 1'b0);

    for (int s = 0; s < 10; s++) step();

    // Never acknowledge: watchdog, then recover at the same index.
    push(6'b0, 1'b1, 8);
    drain("watchdog");
    tick(1);
    clr_err = 1'b1;
    push(6'b0, 1'b0, 2);
    push(dword(m_steps % 3), 1'b0, 1);
    tick(1);
    clr_err = 1'b0;
    drain("clr_resume");

    for (int s = 0; s < 3; s++) step();

    // Asynchronous reset in the middle of a spacer.
    data_half($urandom_range(3, 0), 1'b0);
    #1;
    if ((m_steps % 3) != 0 || ((m_steps / 3) % 4) != 0) begin
      m_steps = 0;
      push(6'b0, 1'b0, 0);
    end else begin
      m_steps = 0;
    end
    rst_n = 1'b0;
    man = '0;
    clr_err = 1'b0;
    #1;
    chk("async_rst_ph", int'(ph), 0);
    chk("async_rst_idx", int'(active_idx), 0);
    chk("async_rst_rot", int'(rot_cnt), 0);
    chk("async_rst_err", int'(err), 0);
    tick(2);
    push(dword(0), 1'b0, 0);
    rst_n = 1'b1;
    #1;
    chk("release_idx", int'(active_idx), 0);
    drain("post_reset_data");

    for (int s = 0; s < 3; s++) step();

    tick(4);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
